median5_stream_window: RTL and testbench
========================================

# median5_stream_window

Streaming front-end for the 5-number median core. It accepts 4-bit samples over a valid/ready handshake and keeps a sliding 5-sample window per frame. It drives the window into an internal instance of the combinational 5-input median finder and registers the result as a 1-entry output stage with backpressure. It sits directly upstream of the median core and owns all sequencing, framing and flow control around it.

## Interface
- No parameters; data width is fixed at 4 bits to match the median core; window depth is fixed at 5.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream sample present
- in_data  in  4  unsigned sample
- in_last  in  1  qualifies in_data as the final sample of a frame
- in_ready  out  1  block can accept a sample this cycle
- out_valid  out  1  out_data holds a median
- out_data  out  4  median of the 5 most recent samples of the current frame
- out_last  out  1  this median's window ended with the frame's in_last sample
- out_ready  in  1  downstream accepts out_data this cycle
- drop_frame  out  1  one-cycle pulse: a frame ended with fewer than 5 samples

## Operation
- Accept means in_valid && in_ready at a rising edge.
- in_ready = !rst && (!out_valid || out_ready); this is combinational and permits one transfer per cycle under continuous flow.
- Window registers w0 (newest) through w4 (oldest) hold the samples. A 3-bit fill counter saturates at 5.
- On accept: shift, so w0 takes in_data and wN takes w(N-1). The counter increments, saturating at 5.
- Median core inputs are the post-shift window: in_data, w0, w1, w2, w3. The median is computed in the same cycle as the accept.
- Emit rule: if the post-accept count is 5, load out_data with the median, set out_valid=1, and set out_last=in_last.
  - A frame of N≥5 samples yields exactly N−4 medians.
  - Frames shorter than 5 samples yield no medians.
- Frame end: on accept with in_last=1, the counter clears to 0 after the emit decision, so the next sample starts an empty window. Window contents need not be cleared because the counter gates all emits.
- Short frame: if in_last is accepted with a pre-accept count <4, drop_frame=1 for the following cycle only.
- Output stage:
  - out_valid clears on out_ready when no new emit occurs that cycle.
  - When an emit and out_ready happen in the same cycle, the stage is reloaded and out_valid stays 1.
  - out_data and out_last hold stable while out_valid && !out_ready.
- Counter FSM states, encoded as count: EMPTY(0), FILL(1–4), FULL(5).
  - EMPTY to FILL on accept.
  - FILL to FULL on the 5th accept.
  - Any state to EMPTY on accept with in_last, or on rst.
  - No-accept cycles hold state.

## Timing
- Latency: a sample accepted at edge k produces its median with out_valid=1 from edge k onward, visible in cycle k+1. That is 1 cycle of latency.
- Throughput: 1 median per cycle once FULL, with out_ready held high.
- Reset values, all forced while rst=1:
  - out_valid=0, out_data=0, out_last=0, drop_frame=0
  - count=0, window=0
  - in_ready=0
- Reset mid-frame: the partial window is discarded and any pending median is dropped without a handshake. The first median after reset needs 5 fresh accepts.
- in_valid while in_ready=0: no accept, no state change, and the sample must be held upstream.
- in_last on the 5th-or-later sample: a normal emit with out_last=1, and no drop_frame.
- in_last with exactly 4 prior samples: this is the 5th sample, so it produces one median and no drop.

## Test plan
- Send 3,9,1,7,5 with in_last on 5, out_ready=1. Expect exactly one transfer: out_data=5, out_last=1, out_valid high 1 cycle after the 5th accept. drop_frame stays 0.
- Send 8,2,6,4,0,15,14 back-to-back as one frame (last on 14), out_ready=1. Expect out_data 4, 4, 6 in consecutive cycles. out_last=1 only on the 6. in_ready stays 1 throughout.
- Run the previous stream with out_ready=0 for 3 cycles after the first median. Expect out_data=4 held, in_ready=0, no accepts, window frozen. After release, the remaining medians are 4 and 6 with none lost or duplicated.
- Send short frame 1,2,3 (last on 3). Expect no out_valid and drop_frame=1 for exactly one cycle. Then send 12,0,7,9,3 (last on 3). Expect a single median 7, proving the window restarted empty.
- Accept 4,4,4, then assert rst for 1 cycle, then send 10,10,10,10,10. Expect no out_valid before the 5th post-reset accept. Then out_data=10. During rst, all outputs read 0.
- Hold out_valid=1 with out_ready=1 and in_valid=1 every cycle in steady state. Expect one accept and one output transfer per cycle, with out_valid never dropping between medians.

Source files
------------

// File: rtl/median5_stream_window_if.sv
// Stream bundle for the median-of-5 front-end: sample input channel, median
// output channel and the short-frame drop pulse.
interface median5_stream_window_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       drop_frame;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, drop_frame
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, drop_frame
    );
endinterface

// File: rtl/median5_stream_window.sv
// Sliding 5-sample window per frame feeding a combinational median-of-5 core,
// with a 1-entry registered output stage under valid/ready backpressure.
module median5_core (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [3:0] i_c,
    input  logic [3:0] i_d,
    input  logic [3:0] i_e,
    output logic [3:0] o_med
);
    logic [3:0] w_s [5];
    logic [3:0] w_tmp;

    always_comb begin
        w_s[0] = i_a;
        w_s[1] = i_b;
        w_s[2] = i_c;
        w_s[3] = i_d;
        w_s[4] = i_e;
        w_tmp  = '0;
        for (int unsigned p = 0; p < 4; p++) begin
            for (int unsigned q = 0; q < 4 - p; q++) begin
                if (w_s[q] > w_s[q+1]) begin
                    w_tmp    = w_s[q];
                    w_s[q]   = w_s[q+1];
                    w_s[q+1] = w_tmp;
                end
            end
        end
        o_med = w_s[2];
    end
endmodule

module median5_stream_window (
    input logic clk,
    input logic rst,
    median5_stream_window_if.slave s
);
    typedef enum logic [1:0] {S_EMPTY, S_FILL, S_FULL} state_t;

    state_t     r_state;
    logic [2:0] r_count;
    logic [3:0] r_w0, r_w1, r_w2, r_w3;
    logic       r_out_valid;
    logic [3:0] r_out_data;
    logic       r_out_last;
    logic       r_drop;

    logic       w_in_ready;
    logic       w_accept;
    logic [2:0] w_count_next;
    logic [3:0] w_median;

    assign w_in_ready   = !rst && (!r_out_valid || s.out_ready);
    assign w_accept     = s.in_valid && w_in_ready;
    assign w_count_next = (r_state == S_FULL) ? 3'd5 : r_count + 3'd1;

    // The oldest sample never reaches the core, so only four history taps are kept.
    median5_core u_core (
        .i_a   (s.in_data),
        .i_b   (r_w0),
        .i_c   (r_w1),
        .i_d   (r_w2),
        .i_e   (r_w3),
        .o_med (w_median)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_count     <= '0;
            r_w0        <= '0;
            r_w1        <= '0;
            r_w2        <= '0;
            r_w3        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (r_out_valid && s.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_w0 <= s.in_data;
                r_w1 <= r_w0;
                r_w2 <= r_w1;
                r_w3 <= r_w2;
                if (w_count_next == 3'd5) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_median;
                    r_out_last  <= s.in_last;
                end
                // Frame end clears the fill after the emit decision above.
                if (s.in_last) begin
                    r_state <= S_EMPTY;
                    r_count <= '0;
                    r_drop  <= (r_count < 3'd4);
                end else begin
                    r_state <= (w_count_next == 3'd5) ? S_FULL : S_FILL;
                    r_count <= w_count_next;
                end
            end
        end
    end

    assign s.in_ready   = w_in_ready;
    assign s.out_valid  = r_out_valid;
    assign s.out_data   = r_out_data;
    assign s.out_last   = r_out_last;
    assign s.drop_frame = r_drop;
endmodule

// File: tb/tb_median5_stream_window.sv
// Directed table-driven bench for median5_stream_window plus hand-written
// sequences for steady-state streaming and reset with a pending median.
module tb_median5_stream_window;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    median5_stream_window_if bus ();

    median5_stream_window dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic [3:0] d;
        logic       l;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        logic [3:0] e_od;
        logic       e_ol;
        logic       e_drop;
        logic       chkd;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d,
                                input logic l, input logic ordy, input logic e_rdy,
                                input logic e_ov, input logic [3:0] e_od, input logic e_ol,
                                input logic e_drop, input logic chkd);
        vec_t x;
        x.rst = r; x.v = v; x.d = d; x.l = l; x.ordy = ordy;
        x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_od = e_od; x.e_ol = e_ol;
        x.e_drop = e_drop; x.chkd = chkd;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] d,
                         input logic l, input logic ordy);
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = ordy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_med [6];
        logic [3:0] smp;
        n_checks = 0;
        n_errors = 0;
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        // Frame 3,9,1,7,5 -> single median 5 with last
        tbl.push_back(mk(1,0, 0,0,1, 0,0, 0,0,0,1));
        tbl.push_back(mk(0,1, 3,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 9,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 1,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 7,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 5,1,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,0, 0,0,1, 1,1, 5,1,0,1));
        tbl.push_back(mk(0,0, 0,0,1, 1,0, 0,0,0,0));
        // Frame 8,2,6,4,0,15,14 -> 4,4,6
        tbl.push_back(mk(0,1, 8,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 2,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 6,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 4,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 0,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1,15,0,1, 1,1, 4,0,0,1));
        tbl.push_back(mk(0,1,14,1,1, 1,1, 4,0,0,1));
        tbl.push_back(mk(0,0, 0,0,1, 1,1, 6,1,0,1));
        tbl.push_back(mk(0,0, 0,0,1, 1,0, 0,0,0,0));
        // Same frame with 3 stall cycles after the first median
        tbl.push_back(mk(0,1, 8,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 2,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 6,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 4,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 0,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1,15,0,0, 0,1, 4,0,0,1));
        tbl.push_back(mk(0,1,15,0,0, 0,1, 4,0,0,1));
        tbl.push_back(mk(0,1,15,0,0, 0,1, 4,0,0,1));
        tbl.push_back(mk(0,1,15,0,1, 1,1, 4,0,0,1));
        tbl.push_back(mk(0,1,14,1,1, 1,1, 4,0,0,1));
        tbl.push_back(mk(0,0, 0,0,1, 1,1, 6,1,0,1));
        tbl.push_back(mk(0,0, 0,0,1, 1,0, 0,0,0,0));
        // Short frame 1,2,3 then 12,0,7,9,3 -> 7
        tbl.push_back(mk(0,1, 1,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 2,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 3,1,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,0, 0,0,1, 1,0, 0,0,1,0));
        tbl.push_back(mk(0,0, 0,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1,12,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 0,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 7,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 9,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 3,1,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,0, 0,0,1, 1,1, 7,1,0,1));
        tbl.push_back(mk(0,0, 0,0,1, 1,0, 0,0,0,0));
        // 4,4,4 then reset mid-frame, then five 10s
        tbl.push_back(mk(0,1, 4,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 4,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1, 4,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(1,1, 4,0,1, 0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,10,0,1, 1,0, 0,0,0,1));
        tbl.push_back(mk(0,1,10,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1,10,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1,10,0,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,1,10,1,1, 1,0, 0,0,0,0));
        tbl.push_back(mk(0,0, 0,0,1, 1,1,10,1,0,1));
        tbl.push_back(mk(0,0, 0,0,1, 1,0, 0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
            #1;
            chk($sformatf("v%0d in_ready", i),   {3'b0, bus.in_ready},   {3'b0, tbl[i].e_rdy});
            chk($sformatf("v%0d out_valid", i),  {3'b0, bus.out_valid},  {3'b0, tbl[i].e_ov});
            chk($sformatf("v%0d drop_frame", i), {3'b0, bus.drop_frame}, {3'b0, tbl[i].e_drop});
            if (tbl[i].chkd) begin
                chk($sformatf("v%0d out_data", i), bus.out_data, tbl[i].e_od);
                chk($sformatf("v%0d out_last", i), {3'b0, bus.out_last}, {3'b0, tbl[i].e_ol});
            end
        end

        // Steady streaming: 10-sample frame, one accept and one transfer per cycle
        exp_med[0] = 4'd6; exp_med[1] = 4'd9; exp_med[2] = 4'd9;
        exp_med[3] = 4'd9; exp_med[4] = 4'd8; exp_med[5] = 4'd8;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            smp = 4'((i * 3) % 16);
            if (i < 10) drive(1'b0, 1'b1, smp, (i == 9), 1'b1);
            else        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
            #1;
            chk($sformatf("steady%0d in_ready", i), {3'b0, bus.in_ready}, 4'd1);
            chk($sformatf("steady%0d out_valid", i), {3'b0, bus.out_valid}, {3'b0, (i >= 5)});
            if (i >= 5) begin
                chk($sformatf("steady%0d out_data", i), bus.out_data, exp_med[i-5]);
                chk($sformatf("steady%0d out_last", i), {3'b0, bus.out_last}, {3'b0, (i == 10)});
            end
        end

        // Reset while a median is pending: dropped, and the window restarts empty
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("pend out_valid", {3'b0, bus.out_valid}, 4'd1);
        chk("pend out_data", bus.out_data, 4'd1);
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
        #1;
        chk("rst in_ready", {3'b0, bus.in_ready}, 4'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd2, 1'b1, 1'b1);
        #1;
        chk("postrst out_valid", {3'b0, bus.out_valid}, 4'd0);
        chk("postrst out_data", bus.out_data, 4'd0);
        chk("postrst in_ready", {3'b0, bus.in_ready}, 4'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        chk("postrst drop_frame", {3'b0, bus.drop_frame}, 4'd1);
        chk("postrst no emit", {3'b0, bus.out_valid}, 4'd0);
        @(negedge clk);
        #1;
        chk("postrst drop clear", {3'b0, bus.drop_frame}, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
